// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL lock qualification, system reset release and SDRAM power-up timer
module pll_reset_sequencer #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int POWERUP_CYCLES     = 20000,
    parameter int CNT_W              = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    output logic       sys_rst_n,
    output logic       powerup_done,
    output logic [1:0] state,
    output logic [7:0] lock_loss_count
);

    localparam logic [1:0] WAIT_LOCK = 2'b00;
    localparam logic [1:0] STABLE    = 2'b01;
    localparam logic [1:0] POWERUP   = 2'b10;
    localparam logic [1:0] RUN       = 2'b11;

    localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] POWERUP_LAST = CNT_W'(POWERUP_CYCLES - 1);

    logic             lock_meta;
    logic             locked_s;
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             loss;
    logic             sys_rst_n_d;
    logic             powerup_done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            locked_s  <= lock_meta;
        end
    end

    // Outputs are registered from the next state so they move on the transition edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= WAIT_LOCK;
            cnt_q           <= '0;
            sys_rst_n       <= 1'b0;
            powerup_done    <= 1'b0;
            lock_loss_count <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sys_rst_n    <= sys_rst_n_d;
            powerup_done <= powerup_done_d;
            if (loss && (lock_loss_count != 8'hFF)) begin
                lock_loss_count <= lock_loss_count + 8'd1;
            end
        end
    end

    // A lock drop always takes priority over reaching a terminal count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loss    = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (locked_s) begin
                    state_d = STABLE;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = POWERUP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            POWERUP: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    loss    = 1'b1;
                end else if (cnt_q == POWERUP_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d = '0;
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    loss    = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        sys_rst_n_d    = (state_d == POWERUP) || (state_d == RUN);
        powerup_done_d = (state_d == RUN);
    end

    assign state = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - directed self-checking bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

    logic       clk;
    logic       rst_n;
    logic       pll_locked;
    logic       sys_rst_n;
    logic       powerup_done;
    logic [1:0] state;
    logic [7:0] lock_loss_count;

    int n_cmp;
    int n_bad;

    pll_reset_sequencer #(
        .LOCK_STABLE_CYCLES(8),
        .POWERUP_CYCLES    (20),
        .CNT_W             (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pll_locked     (pll_locked),
        .sys_rst_n      (sys_rst_n),
        .powerup_done   (powerup_done),
        .state          (state),
        .lock_loss_count(lock_loss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        pll_locked = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({state, sys_rst_n, powerup_done, lock_loss_count} !== {2'b00, 1'b0, 1'b0, 8'd0}) begin
            n_bad++;
            $display("FAIL reset: state=%b rst=%b done=%b cnt=%0d, want 00 0 0 0",
                     state, sys_rst_n, powerup_done, lock_loss_count);
        end
        @(negedge clk);
        pll_locked = 1'b0;
        rst_n      = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if ({state, sys_rst_n} !== {2'b00, 1'b0}) begin
            n_bad++;
            $display("FAIL idle_no_lock: state=%b rst=%b, want 00 0", state, sys_rst_n);
        end
    endtask

    // Raise lock before E0 and walk E0..E32; expects release at E10, done at E30.
    task automatic run_sequence(input string name, input logic [7:0] exp_cnt);
        logic [1:0] es;
        @(negedge clk);
        pll_locked = 1'b1;
        for (int n = 0; n <= 32; n++) begin
            @(posedge clk);
            #1;
            es = (n < 2) ? 2'b00 : (n < 10) ? 2'b01 : (n < 30) ? 2'b10 : 2'b11;
            n_cmp++;
            if ({state, sys_rst_n, powerup_done, lock_loss_count} !==
                {es, (n >= 10), (n >= 30), exp_cnt}) begin
                n_bad++;
                $display("FAIL %s edge %0d: state=%b rst=%b done=%b cnt=%0d, want %b %b %b %0d",
                         name, n, state, sys_rst_n, powerup_done, lock_loss_count,
                         es, (n >= 10), (n >= 30), exp_cnt);
            end
        end
    endtask

    task automatic test_nominal();
        do_reset();
        run_sequence("nominal", 8'd0);
    endtask

    task automatic test_loss_in_run();
        @(negedge clk);
        pll_locked = 1'b0;
        for (int n = 0; n <= 2; n++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (n < 2) begin
                if ({state, sys_rst_n, powerup_done, lock_loss_count} !== {2'b11, 1'b1, 1'b1, 8'd0}) begin
                    n_bad++;
                    $display("FAIL run_loss edge %0d: state=%b rst=%b done=%b cnt=%0d, want 11 1 1 0",
                             n, state, sys_rst_n, powerup_done, lock_loss_count);
                end
            end else begin
                if ({state, sys_rst_n, powerup_done, lock_loss_count} !== {2'b00, 1'b0, 1'b0, 8'd1}) begin
                    n_bad++;
                    $display("FAIL run_loss edge %0d: state=%b rst=%b done=%b cnt=%0d, want 00 0 0 1",
                             n, state, sys_rst_n, powerup_done, lock_loss_count);
                end
            end
        end
        run_sequence("relock", 8'd1);
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({state, sys_rst_n, powerup_done, lock_loss_count} !== {2'b00, 1'b0, 1'b0, 8'd0}) begin
            n_bad++;
            $display("FAIL async_reset: state=%b rst=%b done=%b cnt=%0d, want 00 0 0 0",
                     state, sys_rst_n, powerup_done, lock_loss_count);
        end
        @(negedge clk);
        rst_n      = 1'b1;
        pll_locked = 1'b0;
        run_sequence("restart", 8'd0);
    endtask

    task automatic test_unstable_lock();
        logic [1:0] es;
        do_reset();
        @(negedge clk);
        pll_locked = 1'b1;
        for (int n = 0; n <= 40; n++) begin
            @(posedge clk);
            #1;
            es = (n < 2) ? 2'b00 : (n < 7) ? 2'b01 : (n < 10) ? 2'b00 :
                 (n < 18) ? 2'b01 : (n < 38) ? 2'b10 : 2'b11;
            n_cmp++;
            if ({state, sys_rst_n, lock_loss_count} !== {es, (n >= 18), 8'd0}) begin
                n_bad++;
                $display("FAIL unstable edge %0d: state=%b rst=%b cnt=%0d, want %b %b 0",
                         n, state, sys_rst_n, lock_loss_count, es, (n >= 18));
            end
            if (n == 4) pll_locked = 1'b0;
            if (n == 7) pll_locked = 1'b1;
        end
    endtask

    // Drop arranged so the synchronized low coincides with POWERUP counter 19.
    task automatic test_loss_in_powerup();
        logic [1:0] es;
        do_reset();
        @(negedge clk);
        pll_locked = 1'b1;
        for (int n = 0; n <= 40; n++) begin
            @(posedge clk);
            #1;
            es = (n < 2) ? 2'b00 : (n < 10) ? 2'b01 : (n < 30) ? 2'b10 : 2'b00;
            n_cmp++;
            if ({state, sys_rst_n, powerup_done, lock_loss_count} !==
                {es, (n >= 10 && n < 30), 1'b0, 8'((n >= 30) ? 1 : 0)}) begin
                n_bad++;
                $display("FAIL pwr_loss edge %0d: state=%b rst=%b done=%b cnt=%0d, want %b %b 0 %0d",
                         n, state, sys_rst_n, powerup_done, lock_loss_count,
                         es, (n >= 10 && n < 30), (n >= 30) ? 1 : 0);
            end
            if (n == 27) pll_locked = 1'b0;
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            pll_locked = 1'b1;
            repeat (11) @(posedge clk);
            #1;
            n_cmp++;
            if ({state, sys_rst_n} !== {2'b10, 1'b1}) begin
                n_bad++;
                $display("FAIL sat_entry %0d: state=%b rst=%b, want 10 1", i, state, sys_rst_n);
            end
            @(negedge clk);
            pll_locked = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            n_cmp++;
            if ({state, lock_loss_count} !== {2'b00, 8'((i < 255) ? i + 1 : 255)}) begin
                n_bad++;
                $display("FAIL sat_count %0d: state=%b cnt=%0d, want 00 %0d",
                         i, state, lock_loss_count, (i < 255) ? i + 1 : 255);
            end
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        test_reset();
        test_nominal();
        test_loss_in_run();
        test_async_reset();
        test_unstable_lock();
        test_loss_in_powerup();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
